// File: rtl/rx_frame_deframer.sv
// Receive-side deframer: packs 4-byte command frames from the transceiver
// byte port into 32-bit words behind a 2-entry fall-through FIFO.
module rx_frame_deframer #(
  parameter logic [3:0] HDR_NIBBLE = 4'hF,
  parameter int GAP_TIMEOUT = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       Q,
  input  logic             nRx,
  output logic             nRF,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] sync_err_cnt,
  output logic [CNT_W-1:0] timeout_cnt,
  output logic [CNT_W-1:0] ovf_cnt
);

  localparam int GW = $clog2(GAP_TIMEOUT + 1);
  localparam logic [GW-1:0] GAP_LIM = GW'(GAP_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE, H, B1, B2
  } state_t;

  state_t      state;
  logic [GW-1:0] gap_cnt;
  logic [7:0]  hdr, b1, b2;
  logic [31:0] mem [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count;

  logic        accept, blocked;
  logic        push, pop, do_push, drop;
  logic        rd_nxt;
  logic [1:0]  count_nxt;
  logic [31:0] word, head_nxt;

  always_comb begin
    accept    = !nRx && !nRF;
    blocked   = !nRx && nRF;
    push      = accept && (state == B2);
    pop       = out_valid && out_ready;
    do_push   = push && ((count != 2'd2) || pop);
    drop      = push && !do_push;
    rd_nxt    = rd_ptr ^ pop;
    count_nxt = count + {1'b0, do_push} - {1'b0, pop};
    word      = {hdr, b1, b2, Q};
    head_nxt  = out_data;
    // Head comes straight from the incoming word when it lands in an empty slot.
    if (count_nxt != 2'd0) begin
      if (do_push && (rd_nxt == wr_ptr)) head_nxt = word;
      else head_nxt = mem[rd_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      gap_cnt      <= '0;
      hdr          <= '0;
      b1           <= '0;
      b2           <= '0;
      mem[0]       <= '0;
      mem[1]       <= '0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      count        <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      nRF          <= 1'b0;
      sync_err_cnt <= '0;
      timeout_cnt  <= '0;
      ovf_cnt      <= '0;
    end else begin
      rd_ptr    <= rd_nxt;
      count     <= count_nxt;
      out_valid <= (count_nxt != 2'd0);
      out_data  <= head_nxt;
      nRF       <= (count_nxt == 2'd2);
      if (do_push) begin
        mem[wr_ptr] <= word;
        wr_ptr      <= ~wr_ptr;
      end
      if ((blocked || drop) && (ovf_cnt != '1))
        ovf_cnt <= ovf_cnt + CNT_W'(1);
      unique case (state)
        IDLE: begin
          gap_cnt <= '0;
          if (accept) begin
            if (Q[7:4] == HDR_NIBBLE) begin
              hdr   <= Q;
              state <= H;
            end else if (sync_err_cnt != '1) begin
              sync_err_cnt <= sync_err_cnt + CNT_W'(1);
            end
          end
        end
        H, B1, B2: begin
          if (accept) begin
            gap_cnt <= '0;
            if (state == H) begin
              b1    <= Q;
              state <= B1;
            end else if (state == B1) begin
              b2    <= Q;
              state <= B2;
            end else begin
              state <= IDLE;
            end
          end else if (nRx) begin
            // Byte-free cycle that would reach the limit aborts the frame.
            if (gap_cnt == GAP_LIM) begin
              gap_cnt <= '0;
              state   <= IDLE;
              if (timeout_cnt != '1)
                timeout_cnt <= timeout_cnt + CNT_W'(1);
            end else begin
              gap_cnt <= gap_cnt + GW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_frame_deframer.sv
// Scoreboard bench for rx_frame_deframer: directed frames plus random
// byte traffic compared against a frame-level reference model.
module tb_rx_frame_deframer;

  localparam int CW = 4;
  localparam int GAP = 16;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    Q;
  logic          nRx;
  logic          nRF;
  logic [31:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] sync_err_cnt;
  logic [CW-1:0] timeout_cnt;
  logic [CW-1:0] ovf_cnt;

  rx_frame_deframer #(
    .HDR_NIBBLE(4'hF),
    .GAP_TIMEOUT(GAP),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .Q(Q),
    .nRx(nRx),
    .nRF(nRF),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sync_err_cnt(sync_err_cnt),
    .timeout_cnt(timeout_cnt),
    .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: byte position within a frame, gap length, word queues.
  int          m_pos;
  logic [7:0]  m_b [4];
  int          m_gap;
  int          m_sync, m_to, m_ovf;
  bit          m_nrf;
  bit          m_live = 0;
  bit          m_pop, m_push;
  logic [31:0] m_w;
  logic [31:0] mq [$];
  logic [31:0] sbq [$];

  function automatic int sat(input int v);
    return (v < MAXC) ? v + 1 : v;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pos = 0; m_gap = 0;
      m_sync = 0; m_to = 0; m_ovf = 0;
      m_nrf = 0; m_live = 1;
      mq.delete(); sbq.delete();
    end else if (m_live) begin
      m_pop = (mq.size() > 0) && out_ready;
      m_push = 0;
      if (!nRx) begin
        if (m_nrf) m_ovf = sat(m_ovf);
        else begin
          m_gap = 0;
          if (m_pos == 0) begin
            if (Q[7:4] == 4'hF) begin m_b[0] = Q; m_pos = 1; end
            else m_sync = sat(m_sync);
          end else begin
            m_b[m_pos] = Q;
            if (m_pos == 3) begin
              m_push = 1;
              m_w = {m_b[0], m_b[1], m_b[2], m_b[3]};
              m_pos = 0;
            end else m_pos++;
          end
        end
      end else if (m_pos != 0) begin
        m_gap++;
        if (m_gap == GAP) begin m_pos = 0; m_to = sat(m_to); end
      end
      if (m_pos == 0) m_gap = 0;
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        if (mq.size() == 2) m_ovf = sat(m_ovf);
        else begin mq.push_back(m_w); sbq.push_back(m_w); end
      end
      m_nrf = (mq.size() == 2);
    end
  end

  // Monitor: compare flags/counters each cycle, pop scoreboard on handshake.
  always @(negedge clk) begin
    if (m_live) begin
      chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      chk("nRF", 32'(nRF), 32'(m_nrf));
      chk("sync_err_cnt", 32'(sync_err_cnt), 32'(m_sync));
      chk("timeout_cnt", 32'(timeout_cnt), 32'(m_to));
      chk("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
      if (out_valid) begin
        if (sbq.size() == 0) chk("sb_empty", 32'(out_valid), 32'd0);
        else begin
          chk("out_data", out_data, sbq[0]);
          if (out_ready) void'(sbq.pop_front());
        end
      end
    end
  end

  task automatic cyc(input logic [7:0] q, input logic nrx);
    Q = q;
    nRx = nrx;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    cyc(b, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(8'($urandom), 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(8'h00, 1'b1);
    rst_n = 1'b1;
  endtask

  task automatic send4(input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int k = 3; k >= 0; k--) send(t[k*8 +: 8]);
  endtask

  logic [31:0] fr [3];
  int r;

  initial begin
    Q = 8'h00; nRx = 1'b1; out_ready = 1'b1; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_nRF", 32'(nRF), 32'd0);
    chk("rst_ovf", 32'(ovf_cnt), 32'd0);
    rst_n = 1'b1;
    idle(2);

    send4(32'hF000_0000);
    chk("t1_valid_lat", 32'(out_valid), 32'd1);
    chk("t1_data", out_data, 32'hF000_0000);
    chk("t1_sync", 32'(sync_err_cnt), 32'd0);
    idle(2);

    do_reset();
    send(8'h12);
    send4(32'hF3AA_BBCC);
    chk("t2_data", out_data, 32'hF3AA_BBCC);
    chk("t2_sync", 32'(sync_err_cnt), 32'd1);
    idle(2);

    do_reset();
    send(8'hF0); send(8'h11);
    idle(16);
    send(8'h22); send(8'h33);
    idle(2);
    chk("t3_timeout", 32'(timeout_cnt), 32'd1);
    chk("t3_no_word", 32'(out_valid), 32'd0);
    do_reset();
    send(8'hF0); send(8'h11);
    idle(15);
    send(8'h22); send(8'h33);
    chk("t3_gap15_data", out_data, 32'hF011_2233);
    chk("t3_gap15_to", 32'(timeout_cnt), 32'd0);
    idle(2);

    do_reset();
    out_ready = 1'b0;
    fr[0] = 32'hF1A1_A2A3;
    fr[1] = 32'hF2B1_B2B3;
    fr[2] = 32'hF3C1_C2C3;
    send4(fr[0]);
    send4(fr[1]);
    chk("t4_nRF_full", 32'(nRF), 32'd1);
    send4(fr[2]);
    chk("t4_ovf", 32'(ovf_cnt), 32'd4);
    chk("t4_head", out_data, fr[0]);
    out_ready = 1'b1;
    idle(4);
    chk("t4_nRF_free", 32'(nRF), 32'd0);
    chk("t4_drained", 32'(out_valid), 32'd0);

    do_reset();
    send(8'hF0); send(8'h01);
    do_reset();
    send(8'h02); send(8'h03);
    idle(2);
    chk("t5_sync", 32'(sync_err_cnt), 32'd2);
    chk("t5_no_word", 32'(out_valid), 32'd0);
    send4(32'hF501_0203);
    chk("t5_data", out_data, 32'hF501_0203);
    idle(2);

    do_reset();
    out_ready = 1'b0;
    send4(32'hF6D1_D2D3);
    send(8'hF7); send(8'hE1); send(8'hE2);
    out_ready = 1'b1;
    send(8'hE3);
    chk("t6_ovf", 32'(ovf_cnt), 32'd0);
    chk("t6_head", out_data, 32'hF7E1_E2E3);
    idle(3);

    do_reset();
    repeat (20) send(8'h5A);
    chk("sat_sync", 32'(sync_err_cnt), 32'(MAXC));
    idle(2);

    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      out_ready = ($urandom_range(0, 3) != 0);
      if (r < 1) do_reset();
      else if (r < 4) idle($urandom_range(12, 20));
      else if ($urandom_range(0, 2) != 0)
        cyc({4'hF, 4'($urandom)}, ($urandom_range(0, 3) == 0));
      else
        cyc(8'($urandom), ($urandom_range(0, 3) == 0));
    end
    out_ready = 1'b1;
    idle(6);
    chk("final_sb_empty", 32'(sbq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
